nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit ripple-carry slice over WIDTH/4 nibbles, LSB nibble first.
- Carry is held in a register between nibbles.
- Operands are captured on a start/done handshake, so the wide operation costs one slice plus a small amount of control.
- Sits between a requesting datapath and the 4-bit adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
NIBBLES, WIDTH/4, derived localparam; number of slice passes.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op_sub  input  1  0 = A+B+cin, 1 = A-B (B inverted, carry-in forced 1, cin ignored)
cin  input  1  carry-in for add
a  input  WIDTH  operand A, sampled with start
b  input  WIDTH  operand B, sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  sum/difference
cout  output  1  final carry out (sub: 1 = no borrow)
overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy=0, done=0, result=0, cout=0, overflow=0.
  - Carry register, nibble index and operand registers clear.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1 at a rising edge:
  - Latch a into opA and b into opB. For sub, opB latches ~b.
  - Set carry register to op_sub ? 1 : cin.
  - Clear nibble index k to 0 and go to RUN.
- RUN: each cycle the slice computes opA[4k+3:4k] + opB[4k+3:4k] + carry.
  - The sum nibble is written to result[4k+3:4k].
  - The slice carry-out is written to the carry register and k increments.
  - On k = NIBBLES-1:
    - Compute overflow as (opA[MSB] == opB[MSB]) && (sum[MSB] != opA[MSB]).
    - cout takes the slice carry-out.
    - Go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency: start sampled at edge T.
  - Nibble k is processed in cycle T+1+k.
  - done is high in cycle T+NIBBLES+1. For WIDTH=16 that is 5 cycles after the start edge.
- busy rises in the cycle after start is accepted and falls when the state returns to IDLE.
- start while busy (RUN or DONE) is ignored and not queued.
- result is updated nibble-wise during RUN.
  - It is valid only when done=1, and in the IDLE cycles after done until the next start is accepted.
  - cout and overflow are updated only at the final nibble and hold their value until then.
- On acceptance of a new start, result, cout and overflow are not cleared; the fields are overwritten as nibbles complete.
- Operand inputs may change freely after the start edge; only the latched copies are used.
- Reset mid-operation aborts immediately. No done pulse and no partial result survive (all outputs 0).
- Arithmetic is modulo 2^WIDTH; cout carries the bit WIDTH.

Test Plan:
1. Hold rst_n=0 for 3 cycles, then release -> busy=0, done=0, result=0x0000, cout=0, overflow=0.
2. Add a=0x00FF, b=0x0001, cin=0 -> done high 5 cycles after the start edge; result=0x0100, cout=0, overflow=0. Then a=0x1234, b=0x0000, cin=1 -> result=0x1235.
3. Add a=0xFFFF, b=0x0001 -> result=0x0000, cout=1, overflow=0. Add a=0x7FFF, b=0x0001 -> result=0x8000, cout=0, overflow=1.
4. Sub a=0x0003, b=0x0005 -> result=0xFFFE, cout=0, overflow=0. Sub a=0x8000, b=0x0001 -> result=0x7FFF, cout=1, overflow=1.
5. Pulse start with new operands 2 cycles into RUN -> ignored; exactly one done pulse with the original result; busy=1 from start+1 through the done cycle.
6. Drop rst_n during nibble 2 of an add -> all outputs 0 immediately; no done. After release, a fresh start with 0x0001+0x0001 -> result=0x0002.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/response bundle between a requesting datapath and the nibble-serial adder.
interface nibble_serial_add_ctrl_if #(parameter int WIDTH = 16);
  logic             start;
  logic             op_sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (output start, op_sub, cin, a, b,
                  input  busy, done, result, cout, overflow);
  modport slave  (input  start, op_sub, cin, a, b,
                  output busy, done, result, cout, overflow);
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/sub built from one 4-bit ripple slice reused over WIDTH/4 passes,
// LSB nibble first, with the inter-nibble carry held in a register.
module nsa_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0, ci};
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state, nxt;
  logic [NIBBLES-1:0][3:0]   opa, opb, res_q;
  logic [KW-1:0]             k;
  logic                      carry, cout_q, ovf_q;
  logic [3:0]                sel_a, sel_b, sum;
  logic                      co;

  always_comb begin
    sel_a = opa[k];
    sel_b = opb[k];
  end

  nsa_slice u_slice (.a(sel_a), .b(sel_b), .ci(carry), .s(sum), .co(co));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = RUN;
      RUN:     if (k == KLAST) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Subtract is A + ~B + 1, so B is inverted at capture and carry-in forced high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      res_q  <= '0;
      k      <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          opa   <= bus.a;
          opb   <= bus.op_sub ? ~bus.b : bus.b;
          carry <= bus.op_sub ? 1'b1 : bus.cin;
          k     <= '0;
        end
        RUN: begin
          res_q[k] <= sum;
          carry    <= co;
          k        <= k + 1'b1;
          if (k == KLAST) begin
            cout_q <= co;
            ovf_q  <= (opa[NIBBLES-1][3] == opb[NIBBLES-1][3]) &&
                      (sum[3] != opa[NIBBLES-1][3]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.result   = res_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl at WIDTH=16.
module tb_nibble_serial_add_ctrl;
  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic clk, rst_n;
  int   nvec, nerr;

  nibble_serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();
  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".busy"},     {31'b0, bus.busy},     32'd0);
    chk({tag, ".done"},     {31'b0, bus.done},     32'd0);
    chk({tag, ".result"},   {16'b0, bus.result},   32'h0);
    chk({tag, ".cout"},     {31'b0, bus.cout},     32'd0);
    chk({tag, ".overflow"}, {31'b0, bus.overflow}, 32'd0);
  endtask

  // Issue one op, scramble inputs after the start edge, wait (bounded) for done.
  task automatic run_op(input string tag, input logic sub, input logic ci,
                        input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] er, input logic ec, input logic eo);
    int cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.op_sub = sub; bus.cin = ci; bus.a = av; bus.b = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.a = 16'hA5C3; bus.b = 16'h3C5A; bus.cin = ~ci; bus.op_sub = ~sub;
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (bus.done) break;
    end
    chk({tag, ".latency"},  cnt,                   NIBBLES + 1);
    chk({tag, ".result"},   {16'b0, bus.result},   {16'b0, er});
    chk({tag, ".cout"},     {31'b0, bus.cout},     {31'b0, ec});
    chk({tag, ".overflow"}, {31'b0, bus.overflow}, {31'b0, eo});
    @(negedge clk);
    chk({tag, ".done_1cyc"}, {31'b0, bus.done}, 32'd0);
    chk({tag, ".hold"},      {16'b0, bus.result}, {16'b0, er});
  endtask

  initial begin
    int ndone;
    nvec = 0; nerr = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op_sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outs("reset");

    run_op("add_carry_chain", 1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);
    run_op("add_cin",         1'b0, 1'b1, 16'h1234, 16'h0000, 16'h1235, 1'b0, 1'b0);
    run_op("add_wrap",        1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",         1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    run_op("sub_borrow",      1'b1, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",         1'b1, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op_sub = 1'b0; bus.cin = 1'b0; bus.a = 16'h0011; bus.b = 16'h0022;
    @(posedge clk);
    #1 bus.start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 2) begin
        bus.start = 1'b1; bus.a = 16'h7777; bus.b = 16'h1111; bus.cin = 1'b1;
      end
      if (i == 3) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        chk("ign.result", {16'b0, bus.result}, 32'h0033);
      end
      if (i <= NIBBLES + 1) chk($sformatf("ign.busy%0d", i), {31'b0, bus.busy}, 32'd1);
      if (i == NIBBLES + 2) chk("ign.busy_fall", {31'b0, bus.busy}, 32'd0);
    end
    chk("ign.ndone", ndone, 1);

    // reset during nibble 2 aborts everything
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_idle_outs("abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort.ndone", ndone, 0);
    chk("abort.busy", {31'b0, bus.busy}, 32'd0);
    run_op("post_reset", 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
